// File: rtl/mxu_job_sequencer.sv
// Purpose: runs one mxu matrix-multiply job: load A/B operands, write cycle count, start, poll done, drain SIZE*SIZE results.
// Latency: one operand write per accepted byte; at most one result every 3 cycles; job_done one cycle after the last result handshake.
// Backpressure: op_ready only in LOAD (writes follow op handshakes); the result register holds in RD_OUT until res_ready.
//
// Ports:
//   clk, reset (async, active-low)
//   job_start/job_cycles   : job request (accepted only when idle), cycle count for mxu cache[1]
//   busy/job_done/job_err  : status; job_err is sticky until the next accepted job_start
//   op_valid/op_ready/op_data    : operand byte stream (A row-major, then B row-major)
//   res_valid/res_ready/res_data : accumulator result stream, row-major
//   awaddr/wdata/wready    : mxu write bus (sole master)
//   araddr/arready/rready/rdata : mxu read bus (sole master)
module mxu_job_sequencer #(
  parameter int SIZE    = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        job_start,
  input  logic [7:0]  job_cycles,
  output logic        busy,
  output logic        job_done,
  output logic        job_err,
  input  logic        op_valid,
  output logic        op_ready,
  input  logic [7:0]  op_data,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_data,
  output logic [31:0] awaddr,
  output logic [8:0]  wdata,
  output logic        wready,
  output logic [31:0] araddr,
  output logic        arready,
  output logic        rready,
  input  logic [31:0] rdata
);

  localparam int N  = SIZE * SIZE;
  localparam int KW = $clog2(2 * N + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [KW-1:0] K_LAST_OP  = KW'(2 * N - 1);
  localparam logic [KW-1:0] K_LAST_RES = KW'(N - 1);
  localparam logic [TW-1:0] T_LAST     = TW'(TIMEOUT - 1);

  typedef enum logic [3:0] {
    IDLE,
    LOAD,
    CFG,
    KICK,
    POLL_ADDR,
    POLL,
    RD_ADDR,
    RD_CAP,
    RD_OUT
  } state_t;

  state_t        state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [7:0]    cyc_q, cyc_d;
  logic          err_q, err_d;
  logic          done_q, done_d;
  logic [31:0]   res_q, res_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      k_q     <= '0;
      tcnt_q  <= '0;
      cyc_q   <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      tcnt_q  <= tcnt_d;
      cyc_q   <= cyc_d;
      err_q   <= err_d;
      done_q  <= done_d;
      res_q   <= res_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    tcnt_d   = tcnt_q;
    cyc_d    = cyc_q;
    err_d    = err_q;
    done_d   = 1'b0;
    res_d    = res_q;
    op_ready = 1'b0;
    wready   = 1'b0;
    awaddr   = '0;
    wdata    = '0;
    arready  = 1'b0;
    araddr   = '0;
    rready   = 1'b0;

    case (state_q)
      IDLE: begin
        if (job_start) begin
          cyc_d   = job_cycles;
          err_d   = 1'b0;
          k_d     = '0;
          state_d = LOAD;
        end
      end

      LOAD: begin
        op_ready = 1'b1;
        // The write goes out combinationally with the handshake, so an
        // operand byte is never buffered inside the sequencer.
        if (op_valid) begin
          wready = 1'b1;
          awaddr = 32'(k_q) + 32'd2;
          wdata  = {1'b0, op_data};
          k_d    = k_q + KW'(1);
          if (k_q == K_LAST_OP) state_d = CFG;
        end
      end

      CFG: begin
        wready  = 1'b1;
        awaddr  = 32'd1;
        wdata   = {1'b0, cyc_q};
        state_d = KICK;
      end

      KICK: begin
        wready  = 1'b1;
        awaddr  = 32'd0;
        wdata   = 9'h001;
        state_d = POLL_ADDR;
      end

      POLL_ADDR: begin
        arready = 1'b1;
        tcnt_d  = '0;
        state_d = POLL;
      end

      POLL: begin
        // araddr stays 0 from POLL_ADDR, so rdata tracks the status word.
        if (rdata[1]) begin
          k_d     = '0;
          state_d = RD_ADDR;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
          if (tcnt_d == T_LAST) begin
            err_d   = 1'b1;
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end

      RD_ADDR: begin
        arready = 1'b1;
        araddr  = 32'(k_q) + 32'd1;
        state_d = RD_CAP;
      end

      RD_CAP: begin
        rready  = 1'b1;
        res_d   = rdata;
        state_d = RD_OUT;
      end

      RD_OUT: begin
        rready = 1'b1;
        if (res_ready) begin
          if (k_q == K_LAST_RES) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            k_d     = k_q + KW'(1);
            state_d = RD_ADDR;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign busy      = (state_q != IDLE);
  assign res_valid = (state_q == RD_OUT);
  assign res_data  = res_q;
  assign job_done  = done_q;
  assign job_err   = err_q;

endmodule

// File: tb/tb_mxu_job_sequencer.sv
// Purpose: bench for mxu_job_sequencer with a small behavioural mxu and a matrix-product reference.
// Latency: jobs are driven cycle by cycle; inputs change 1 unit after posedge, outputs are sampled at negedge.
// Backpressure: operand stalls and result-side holds are injected per scenario.
module tb_mxu_job_sequencer;

  localparam int SIZE = 4;
  localparam int N    = SIZE * SIZE;
  localparam int TMO  = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        job_start;
  logic [7:0]  job_cycles;
  logic        busy, job_done, job_err;
  logic        op_valid, op_ready;
  logic [7:0]  op_data;
  logic        res_valid, res_ready;
  logic [31:0] res_data;
  logic [31:0] awaddr, araddr, rdata;
  logic [8:0]  wdata;
  logic        wready, arready, rready;

  always #5 clk = ~clk;

  mxu_job_sequencer #(.SIZE(SIZE), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .job_start(job_start), .job_cycles(job_cycles),
    .busy(busy), .job_done(job_done), .job_err(job_err),
    .op_valid(op_valid), .op_ready(op_ready), .op_data(op_data),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .awaddr(awaddr), .wdata(wdata), .wready(wready),
    .araddr(araddr), .arready(arready), .rready(rready), .rdata(rdata)
  );

  // ---------------- behavioural mxu ----------------
  logic [8:0]  cache [0:2*N+1];
  logic [31:0] araddr_q = 32'd0;
  int          mcnt = 0;
  logic        m_run = 1'b0;
  logic        m_done = 1'b0;
  bit          never_done = 1'b0;

  always @(posedge clk) begin
    if (arready) araddr_q <= araddr;
    if (wready) begin
      if (awaddr < 32'(2*N+2)) cache[awaddr[5:0]] <= wdata;
      if (awaddr == 32'd0 && wdata[0]) begin
        m_run  <= 1'b1;
        m_done <= 1'b0;
        mcnt   <= 0;
      end
    end else if (m_run) begin
      if (mcnt >= int'(cache[1])) begin
        m_run  <= 1'b0;
        m_done <= !never_done;
      end else begin
        mcnt <= mcnt + 1;
      end
    end
  end

  function automatic logic [31:0] mxu_prod(input int idx);
    logic [31:0] s = 32'd0;
    for (int j = 0; j < SIZE; j++)
      s += 32'(cache[2 + (idx / SIZE) * SIZE + j][7:0]) * 32'(cache[2 + N + j * SIZE + (idx % SIZE)][7:0]);
    return s;
  endfunction

  always_comb begin
    rdata = 32'd0;
    if (araddr_q == 32'd0) rdata = {30'd0, m_done, m_run};
    else if (araddr_q <= 32'(N)) rdata = mxu_prod(int'(araddr_q) - 1);
  end

  // ---------------- reference model and bookkeeping ----------------
  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [7:0]  op_bytes [0:2*N-1];
  logic [7:0]  jcyc;
  logic [31:0] got_q [$];
  logic [31:0] wr_a_q [$];
  logic [8:0]  wr_d_q [$];
  int wr_viol, ar_in_res, done_cnt, overlap, stab_viol, hold_cnt, poll_cyc, done_cyc;
  bit done_seen, err_at_done, err_after_start, busy_after_start;

  // C[r][c] = sum_j A[r][j] * B[j][c], row-major index idx = r*SIZE + c
  function automatic logic [31:0] ref_result(input int idx);
    logic [31:0] s = 32'd0;
    int r = idx / SIZE;
    int c = idx % SIZE;
    for (int j = 0; j < SIZE; j++)
      s += 32'(op_bytes[r * SIZE + j]) * 32'(op_bytes[N + j * SIZE + c]);
    return s;
  endfunction

  // Expected write trace: operands to 2..2N+1 in order, then cycles to 1, then start to 0.
  function automatic int trace_errs();
    int e = 0;
    if (wr_a_q.size() != 2*N + 2) return 1000 + wr_a_q.size();
    for (int i = 0; i < 2*N; i++)
      if (wr_a_q[i] !== 32'(i + 2) || wr_d_q[i] !== {1'b0, op_bytes[i]}) e++;
    if (wr_a_q[2*N] !== 32'd1 || wr_d_q[2*N] !== {1'b0, jcyc}) e++;
    if (wr_a_q[2*N+1] !== 32'd0 || wr_d_q[2*N+1] !== 9'h001) e++;
    return e;
  endfunction

  function automatic int result_errs();
    int e = 0;
    for (int i = 0; i < got_q.size(); i++)
      if (got_q[i] !== ref_result(i)) e++;
    return e;
  endfunction

  task automatic fill_random();
    for (int i = 0; i < 2*N; i++) op_bytes[i] = 8'($urandom);
    jcyc = 8'($urandom_range(0, 10));
  endtask

  task automatic tick();
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  // Runs one job from the current posedge+1 point until job_done (bounded).
  task automatic run_job(input bit stall, input int bp_idx, input int bp_len, input bit mid_start);
    int idx = 0;
    int n = 0;
    bit tog = 1'b0;
    bit held_v = 1'b0;
    logic [31:0] held = 32'd0;
    got_q.delete(); wr_a_q.delete(); wr_d_q.delete();
    wr_viol = 0; ar_in_res = 0; done_cnt = 0; overlap = 0; stab_viol = 0;
    hold_cnt = 0; poll_cyc = -1; done_cyc = -1; done_seen = 1'b0; err_at_done = 1'b0;
    job_cycles = jcyc;
    job_start  = 1'b1;
    @(posedge clk); #1;
    job_start = 1'b0;
    err_after_start  = job_err;
    busy_after_start = busy;
    while (!done_seen && n < 3000) begin
      op_valid   = (idx < 2*N) && (!stall || tog);
      op_data    = op_bytes[(idx < 2*N) ? idx : 0];
      job_start  = mid_start && (n == 5);
      job_cycles = (mid_start && n == 5) ? 8'hEE : jcyc;
      res_ready  = 1'b1;
      if (res_valid && got_q.size() == bp_idx && hold_cnt < bp_len) begin
        res_ready = 1'b0;
        hold_cnt++;
      end
      @(negedge clk);
      cyc++;
      if (held_v && res_data !== held) stab_viol++;
      held_v = res_valid && !res_ready;
      held   = res_data;
      if (wready) begin
        wr_a_q.push_back(awaddr);
        wr_d_q.push_back(wdata);
      end
      if (op_ready && (wready !== op_valid)) wr_viol++;
      if (res_valid && arready) ar_in_res++;
      if (arready && araddr == 32'd0) poll_cyc = cyc;
      if (job_done) begin
        done_cnt++;
        done_cyc    = cyc;
        done_seen   = 1'b1;
        err_at_done = job_err;
        if (res_valid) overlap++;
      end
      if (op_valid && op_ready) idx++;
      if (res_valid && res_ready) got_q.push_back(res_data);
      tog = !tog;
      n++;
      @(posedge clk); #1;
    end
    op_valid  = 1'b0;
    job_start = 1'b0;
    res_ready = 1'b1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    int e;
    reset = 1'b0;
    #2;
    checks++;
    if ({busy, job_done, job_err, op_ready, res_valid, wready, arready, rready} !== 8'd0 ||
        res_data !== 32'd0 || awaddr !== 32'd0 || araddr !== 32'd0 || wdata !== 9'd0) begin
      errors++;
      $display("FAIL reset_init: flags=%b res_data=%h awaddr=%h araddr=%h wdata=%h, required all zero",
               {busy, job_done, job_err, op_ready, res_valid, wready, arready, rready}, res_data, awaddr, araddr, wdata);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    tick();

    fill_random();
    job_cycles = jcyc;
    job_start  = 1'b1;
    tick();
    job_start = 1'b0;
    op_valid  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      op_data = op_bytes[i];
      tick();
    end
    op_data = op_bytes[5];
    checks++;
    if (busy !== 1'b1 || wready !== 1'b1 || awaddr !== 32'd7) begin
      errors++;
      $display("FAIL reset_preload: busy=%b wready=%b awaddr=%0d, required 1 1 7", busy, wready, awaddr);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({busy, job_done, job_err, op_ready, res_valid, wready, arready, rready} !== 8'd0 ||
        res_data !== 32'd0 || awaddr !== 32'd0 || araddr !== 32'd0 || wdata !== 9'd0) begin
      errors++;
      $display("FAIL reset_midload: flags=%b res_data=%h awaddr=%h araddr=%h wdata=%h, required all zero",
               {busy, job_done, job_err, op_ready, res_valid, wready, arready, rready}, res_data, awaddr, araddr, wdata);
    end
    op_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    tick();

    fill_random();
    run_job(1'b0, -1, 0, 1'b0);
    e = result_errs();
    checks++;
    if (!done_seen || got_q.size() != N || e != 0) begin
      errors++;
      $display("FAIL reset_rerun: done=%0d results=%0d wrong=%0d, required done=1 results=%0d wrong=0",
               done_seen, got_q.size(), e, N);
    end
  endtask

  task automatic test_identity();
    int e;
    for (int i = 0; i < N; i++) op_bytes[i] = (i / SIZE == i % SIZE) ? 8'd1 : 8'd0;
    for (int i = 0; i < N; i++) op_bytes[N + i] = 8'(i + 1);
    jcyc = 8'd10;
    run_job(1'b0, -1, 0, 1'b0);
    e = trace_errs();
    checks++;
    if (e != 0) begin
      errors++;
      $display("FAIL identity_writes: %0d bad (of %0d writes), required 0 bad of %0d", e, wr_a_q.size(), 2*N + 2);
    end
    e = 0;
    for (int i = 0; i < got_q.size(); i++) if (got_q[i] !== 32'(i + 1)) e++;
    checks++;
    if (got_q.size() != N || e != 0) begin
      errors++;
      $display("FAIL identity_results: results=%0d wrong=%0d, required %0d values 1..%0d", got_q.size(), e, N, N);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (job_done) done_cnt++;
      @(posedge clk); #1;
    end
    checks++;
    if (done_cnt != 1 || overlap != 0 || err_at_done !== 1'b0) begin
      errors++;
      $display("FAIL identity_done: pulses=%0d overlap=%0d err=%b, required 1 0 0", done_cnt, overlap, err_at_done);
    end
  endtask

  task automatic test_operand_stall();
    int e;
    run_job(1'b1, -1, 0, 1'b0);
    e = trace_errs();
    checks++;
    if (e != 0 || wr_viol != 0) begin
      errors++;
      $display("FAIL stall_writes: trace_bad=%0d strobe_viol=%0d, required 0 0", e, wr_viol);
    end
    e = 0;
    for (int i = 0; i < got_q.size(); i++) if (got_q[i] !== 32'(i + 1)) e++;
    checks++;
    if (got_q.size() != N || e != 0) begin
      errors++;
      $display("FAIL stall_results: results=%0d wrong=%0d, required %0d wrong=0", got_q.size(), e, N);
    end
  endtask

  task automatic test_result_backpressure();
    int e;
    fill_random();
    run_job(1'b0, 5, 7, 1'b0);
    checks++;
    if (hold_cnt != 7 || stab_viol != 0 || ar_in_res != 0) begin
      errors++;
      $display("FAIL bp_hold: held=%0d unstable=%0d arready_during_valid=%0d, required 7 0 0",
               hold_cnt, stab_viol, ar_in_res);
    end
    e = result_errs();
    checks++;
    if (!done_seen || got_q.size() != N || e != 0) begin
      errors++;
      $display("FAIL bp_results: done=%0d results=%0d wrong=%0d, required 1 %0d 0", done_seen, got_q.size(), e, N);
    end
  endtask

  task automatic test_timeout();
    int e;
    fill_random();
    never_done = 1'b1;
    run_job(1'b0, -1, 0, 1'b0);
    never_done = 1'b0;
    checks++;
    if (!done_seen || err_at_done !== 1'b1 || got_q.size() != 0) begin
      errors++;
      $display("FAIL timeout_flag: done=%0d err=%b results=%0d, required 1 1 0", done_seen, err_at_done, got_q.size());
    end
    checks++;
    if (done_cyc - poll_cyc != TMO) begin
      errors++;
      $display("FAIL timeout_delay: done %0d cycles after poll addr, required %0d", done_cyc - poll_cyc, TMO);
    end
    fill_random();
    run_job(1'b0, -1, 0, 1'b0);
    e = result_errs();
    checks++;
    if (err_after_start !== 1'b0 || !done_seen || got_q.size() != N || e != 0 || err_at_done !== 1'b0) begin
      errors++;
      $display("FAIL timeout_recover: err_after_start=%b done=%0d results=%0d wrong=%0d, required 0 1 %0d 0",
               err_after_start, done_seen, got_q.size(), e, N);
    end
  endtask

  task automatic test_back_to_back();
    int e;
    fill_random();
    run_job(1'b0, -1, 0, 1'b0);
    e = result_errs();
    checks++;
    if (!done_seen || got_q.size() != N || e != 0) begin
      errors++;
      $display("FAIL b2b_first: done=%0d results=%0d wrong=%0d, required 1 %0d 0", done_seen, got_q.size(), e, N);
    end
    fill_random();
    run_job(1'b0, -1, 0, 1'b1);
    checks++;
    if (busy_after_start !== 1'b1) begin
      errors++;
      $display("FAIL b2b_accept: busy=%b after start in cycle following job_done, required 1", busy_after_start);
    end
    e = trace_errs();
    checks++;
    if (e != 0) begin
      errors++;
      $display("FAIL b2b_ignore_start: %0d bad writes, required 0", e);
    end
    e = result_errs();
    checks++;
    if (!done_seen || got_q.size() != N || e != 0 || done_cnt != 1) begin
      errors++;
      $display("FAIL b2b_second: done=%0d results=%0d wrong=%0d pulses=%0d, required 1 %0d 0 1",
               done_seen, got_q.size(), e, done_cnt, N);
    end
  endtask

  initial begin
    reset      = 1'b0;
    job_start  = 1'b0;
    job_cycles = 8'd0;
    op_valid   = 1'b0;
    op_data    = 8'd0;
    res_ready  = 1'b1;
    jcyc       = 8'd0;
    test_reset();
    test_identity();
    test_operand_stall();
    test_result_backpressure();
    test_timeout();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit, required completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mxu_job_sequencer.md
Name: mxu_job_sequencer

Overview:
- Sequences one matrix-multiply job on the mxu write/read bus: streams A and B operand bytes into the mxu cache, writes the cycle count, sets start, polls status for done, then drains the SIZE*SIZE accumulator results to an output stream.
- Sits between the host-side operand/result streams and the mxu. It is the sole master of the mxu awaddr/wdata/wready/araddr/arready/rready pins.

Parameters:
- SIZE, 4, systolic array dimension; matches the mxu instance.
- TIMEOUT, 1024, maximum POLL cycles before an error is flagged.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- job_start  in  1  one-cycle pulse; accepted only in IDLE
- job_cycles  in  8  value written to mxu cache[1]; sampled on an accepted job_start
- busy  out  1  high in every state except IDLE
- job_done  out  1  one-cycle pulse after the last result handshake
- job_err  out  1  sticky timeout flag; cleared by the next accepted job_start
- op_valid  in  1  operand byte valid
- op_ready  out  1  operand byte accepted when op_valid && op_ready
- op_data  in  8  operand byte; A row-major, then B row-major
- res_valid  out  1  result valid
- res_ready  in  1  result accepted when res_valid && res_ready
- res_data  out  32  accumulator result, row-major index k
- awaddr  out  32  mxu write address
- wdata  out  9  mxu write data
- wready  out  1  mxu write strobe
- araddr  out  32  mxu read address
- arready  out  1  mxu read-address strobe
- rready  out  1  high in READ
- rdata  in  32  mxu read data; reflects the araddr captured on the previous arready cycle

Behaviour:
- Constants: N = SIZE*SIZE. Index counter k has width clog2(2N+1).
- Reset (asynchronous, reset=0):
  - state = IDLE.
  - All outputs 0, including awaddr, araddr and res_data.
  - k = 0, timeout counter = 0, job_err = 0.
- IDLE:
  - On job_start: latch job_cycles, clear job_err, k = 0, go to LOAD.
  - job_start in any other state is ignored.
- LOAD:
  - op_ready = 1.
  - On an op handshake, in the same cycle: wready = 1, awaddr = k+2, wdata = {1'b0, op_data}, k++.
  - Without a handshake, wready = 0.
  - After the handshake with k = 2N-1: go to CFG.
- CFG: one cycle; wready = 1, awaddr = 1, wdata = {1'b0, latched cycles}. Go to KICK.
- KICK: one cycle; wready = 1, awaddr = 0, wdata = 9'h001. Go to POLL_ADDR.
- POLL_ADDR: one cycle; arready = 1, araddr = 0. Clear the timeout counter. Go to POLL.
- POLL:
  - arready = 0; araddr is held at 0, so rdata continuously shows mxu status.
  - If rdata[1] = 1: k = 0, go to RD_ADDR.
  - Otherwise increment the timeout counter. When the counter reaches TIMEOUT-1: set job_err, pulse job_done, go to IDLE. No results are emitted.
- RD_ADDR: one cycle; arready = 1, araddr = k+1. Go to RD_CAP.
- RD_CAP: one cycle; rready = 1. Register rdata into res_data, set res_valid. Go to RD_OUT.
- RD_OUT:
  - rready = 1; hold res_valid and res_data stable until res_ready.
  - On a handshake: res_valid = 0. If k = N-1, pulse job_done and go to IDLE; otherwise k++ and go to RD_ADDR.
- Result throughput is at most one per 3 cycles; job_done is never asserted in the same cycle as res_valid.
- wready is asserted only in LOAD (on a handshake), CFG and KICK, so no write ever coincides with an mxu done event.
- reset asserted mid-job aborts immediately to the reset values. Any partial mxu state is overwritten by the next full job.

Test Plan:
- Reset: drive reset=0 mid-LOAD (after 5 operands) -> all outputs 0, busy = 0, state IDLE; a new job then runs to completion with the correct results.
- Identity job (SIZE=4): A = I, B = 1..16, job_cycles = 10, op_valid held high -> exactly 32 writes to awaddr 2..33, then (1, 0x00A), then (0, 0x001); results are 16 values 1..16 in order; job_done fires once.
- Operand stalls: toggle op_valid every other cycle -> wready only on handshake cycles, awaddr contiguous with no skips or duplicates, same results as the unstalled run.
- Result backpressure: hold res_ready low 7 cycles on result 5 -> res_data stays stable and no new arready is issued; all 16 results are delivered in order.
- Timeout: mxu model never sets status bit1, TIMEOUT = 16 -> job_err = 1 and job_done pulses 16 cycles after POLL_ADDR, no res_valid; the next job_start clears job_err.
- Back-to-back jobs: job_start in the cycle after job_done, with a second matrix pair -> second result set is correct; a job_start asserted while busy is ignored.
